// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU / unified-memory arbiter.
package cpu_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    // Word-address width carried in a latched request (byte address up to 32 bits).
    localparam int unsigned REQ_AW = 30;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        PORT_IF,
        PORT_D
    } port_t;

    typedef struct packed {
        logic              we;
        logic [REQ_AW-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

    // True when a word address falls inside a memory of the given depth.
    function automatic logic word_in_range(input logic [REQ_AW-1:0] waddr,
                                           input int unsigned       depth);
        return waddr < REQ_AW'(depth);
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
module arb_starve_cnt #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    // Next streak value: clear wins, increment saturates at LIMIT.
    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (inc && (count != CW'(LIMIT))) begin
            count_nxt = count + CW'(1);
        end
    end

    // Streak register with the limit flag registered alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            at_limit <= 1'b0;
        end else begin
            count    <= count_nxt;
            at_limit <= (count_nxt == CW'(LIMIT));
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-port memory,
// one access in flight, data priority with a fetch anti-starvation limit.
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_req,
    input  logic [AW-1:0]            if_addr,
    output logic                     if_ready,
    output logic                     if_rvalid,
    output logic [DATA_W-1:0]        if_rdata,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [AW-1:0]            d_addr,
    input  logic [DATA_W-1:0]        d_wdata,
    input  logic [BE_W-1:0]          d_be,
    output logic                     d_ready,
    output logic                     d_rvalid,
    output logic [DATA_W-1:0]        d_rdata,
    output logic                     d_err,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [BE_W-1:0]          mem_be,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int unsigned MAW   = $clog2(DEPTH);
    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t        state;
    port_t             owner;
    mem_req_t          req_q;
    logic              oor_q;
    logic [LAT_W-1:0]  lat_cnt;

    logic              idle;
    logic              at_limit;
    logic              grant_if;
    logic              grant_d;
    logic              grant_any;
    logic              streak_inc;
    logic              streak_clr;
    logic [REQ_AW-1:0] if_waddr;
    logic [REQ_AW-1:0] d_waddr;
    mem_req_t          sel_req;
    port_t             sel_port;
    logic              sel_oor;
    logic              unused_addr_bits;

    assign if_waddr = REQ_AW'(if_addr[AW-1:2]);
    assign d_waddr  = REQ_AW'(d_addr[AW-1:2]);

    // Byte offsets and word-address bits above the memory are never used as an address.
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0], req_q.addr[REQ_AW-1:MAW]};

    // Requests are only accepted out of reset and while idle.
    assign idle = reset && (state == IDLE);

    // Data wins unless the fetch port has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (idle) begin
            grant_d  = d_req && !(if_req && at_limit);
            grant_if = if_req && !grant_d;
        end
    end

    assign grant_any = grant_d | grant_if;
    assign if_ready  = grant_if;
    assign d_ready   = grant_d;

    // Streak grows on each data grant that leaves a fetch waiting.
    assign streak_inc = grant_d && if_req;
    assign streak_clr = idle && (grant_if || !if_req);

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (streak_inc),
        .clr      (streak_clr),
        .at_limit (at_limit)
    );

    // Build the request of whichever port is granted; fetches are always reads.
    always_comb begin
        sel_req  = '0;
        sel_port = PORT_D;
        if (grant_if) begin
            sel_port     = PORT_IF;
            sel_req.addr = if_waddr;
        end else begin
            sel_req.we    = d_we;
            sel_req.addr  = d_waddr;
            sel_req.wdata = d_wdata;
            sel_req.be    = d_we ? d_be : '0;
        end
        sel_oor = !word_in_range(sel_req.addr, DEPTH);
    end

    // Access sequencer: latch on accept, strobe memory once, respond after MEM_LAT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= PORT_IF;
            req_q     <= '0;
            oor_q     <= 1'b0;
            lat_cnt   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner   <= sel_port;
                        req_q   <= sel_req;
                        oor_q   <= sel_oor;
                        lat_cnt <= LAT_W'(MEM_LAT - 1);
                        mem_en  <= !sel_oor;
                        mem_we  <= sel_req.we && !sel_oor;
                        state   <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= IDLE;
                        d_err <= oor_q;
                        if (owner == PORT_D) begin
                            d_rvalid <= 1'b1;
                        end else begin
                            if_rvalid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                        state   <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory command fields come straight from the latched request.
    assign mem_addr  = MAW'(req_q.addr);
    assign mem_wdata = req_q.wdata;
    assign mem_be    = req_q.be;

    // Read data passes through in the response cycle; zero for stores and bad addresses.
    assign if_rdata = (if_rvalid && !oor_q) ? mem_rdata : '0;
    assign d_rdata  = (d_rvalid && !oor_q && !req_q.we) ? mem_rdata : '0;

    // Responses never collide and nothing is accepted while an access is in flight.
    a_rvalid_excl: assert property (@(posedge clk) disable iff (!reset)
        !(if_rvalid && d_rvalid));
    a_ready_idle: assert property (@(posedge clk) disable iff (!reset)
        (if_ready || d_ready) |-> (state == IDLE));

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: two instances (MEM_LAT 1 and 2) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_cpu_mem_arbiter;

    localparam int DEPTH = 64;
    localparam int LIMIT = 4;
    localparam int LAT0  = 1;
    localparam int LAT1  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]       if_req, d_req, d_we;
    logic [1:0][31:0] if_addr, d_addr, d_wdata;
    logic [1:0][3:0]  d_be;
    logic [1:0]       if_ready, if_rvalid, d_ready, d_rvalid, d_err, mem_en, mem_we;
    logic [1:0][31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [1:0][3:0]  mem_be;
    logic [1:0][5:0]  mem_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    cpu_mem_arbiter #(.AW(32), .DEPTH(DEPTH), .MEM_LAT(LAT0), .STARVE_LIMIT(LIMIT)) u_dut0 (
        .clk(clk), .reset(reset),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ready(if_ready[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_be(d_be[0]), .d_ready(d_ready[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .d_err(d_err[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_be(mem_be[0]), .mem_rdata(mem_rdata[0])
    );

    cpu_mem_arbiter #(.AW(32), .DEPTH(DEPTH), .MEM_LAT(LAT1), .STARVE_LIMIT(LIMIT)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ready(if_ready[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_be(d_be[1]), .d_ready(d_ready[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .d_err(d_err[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_be(mem_be[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic logic [31:0] init_word(input int k, input int i);
        if (i == 2) return 32'h0020_0113;
        return 32'hA500_0000 | (32'(k) << 8) | 32'(i);
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%08h expected 0x%08h (cycle %0d)", k, name, act, exp, cyc);
        end
    endtask

    // Bench memory: registered read, second pipeline stage for the MEM_LAT=2 instance.
    logic [31:0] ram [2][DEPTH];
    logic [31:0] pipe0 [2];
    logic [31:0] pipe1 [2];
    logic        ram_init;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!ram_init) begin
                for (int i = 0; i < DEPTH; i++) ram[k][i] <= init_word(k, i);
            end else if (mem_en[k]) begin
                pipe0[k] <= ram[k][mem_addr[k]];
                if (mem_we[k])
                    for (int b = 0; b < 4; b++)
                        if (mem_be[k][b]) ram[k][mem_addr[k]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
            end
            pipe1[k] <= pipe0[k];
        end
    end

    assign mem_rdata[0] = pipe0[0];
    assign mem_rdata[1] = pipe1[1];

    // Transaction-level model: one pending access per instance, tracked by cycle numbers.
    logic [31:0] mm [2][DEPTH];
    bit          m_pend [2];
    bit          m_isd  [2];
    bit          m_we   [2];
    bit          m_oor  [2];
    logic [31:0] m_rd   [2];
    logic [31:0] m_wd   [2];
    logic [3:0]  m_be   [2];
    int          m_idx  [2];
    int          m_acc  [2];
    int          m_resp [2];
    int          m_streak [2];

    task automatic model_step(input int k);
        bit e_ir, e_dr, e_iv, e_dv, e_err, e_en, e_we, gi, gd;
        logic [31:0] e_rd, waddr;
        e_ir = 0; e_dr = 0; e_iv = 0; e_dv = 0; e_err = 0; e_en = 0; e_we = 0; e_rd = 0;
        if (!reset) begin
            m_pend[k]   = 0;
            m_streak[k] = 0;
        end else begin
            if (m_pend[k] && cyc == m_resp[k]) begin
                if (m_isd[k]) e_dv = 1; else e_iv = 1;
                e_rd      = m_rd[k];
                e_err     = m_oor[k];
                m_pend[k] = 0;
            end
            if (m_pend[k] && cyc == m_acc[k] + 1 && !m_oor[k]) begin
                e_en = 1;
                e_we = m_we[k];
            end
            if (!m_pend[k]) begin
                gd = d_req[k] && !(if_req[k] && m_streak[k] == LIMIT);
                gi = if_req[k] && !gd;
                e_ir = gi;
                e_dr = gd;
                if (gi || !if_req[k]) m_streak[k] = 0;
                else if (gd && m_streak[k] < LIMIT) m_streak[k]++;
                if (gi || gd) begin
                    waddr     = (gd ? d_addr[k] : if_addr[k]) >> 2;
                    m_oor[k]  = (waddr >= DEPTH);
                    m_idx[k]  = int'(waddr % DEPTH);
                    m_isd[k]  = gd;
                    m_we[k]   = gd && d_we[k];
                    m_wd[k]   = d_wdata[k];
                    m_be[k]   = d_be[k];
                    m_rd[k]   = (m_oor[k] || m_we[k]) ? 32'h0 : mm[k][m_idx[k]];
                    if (m_we[k] && !m_oor[k])
                        for (int b = 0; b < 4; b++)
                            if (m_be[k][b]) mm[k][m_idx[k]][8*b +: 8] = m_wd[k][8*b +: 8];
                    m_acc[k]  = cyc;
                    m_resp[k] = cyc + 1 + lat_of(k);
                    m_pend[k] = 1;
                end
            end
        end
        chk(k, "if_ready",  if_ready[k],  e_ir);
        chk(k, "d_ready",   d_ready[k],   e_dr);
        chk(k, "if_rvalid", if_rvalid[k], e_iv);
        chk(k, "d_rvalid",  d_rvalid[k],  e_dv);
        chk(k, "d_err",     d_err[k],     e_err);
        chk(k, "mem_en",    mem_en[k],    e_en);
        chk(k, "mem_we",    mem_we[k],    e_we);
        if (e_iv) chk(k, "if_rdata", if_rdata[k], e_rd);
        if (e_dv) chk(k, "d_rdata",  d_rdata[k],  e_rd);
        if (e_en) chk(k, "mem_addr", 32'(mem_addr[k]), 32'(m_idx[k]));
        if (e_we) begin
            chk(k, "mem_wdata", mem_wdata[k], m_wd[k]);
            chk(k, "mem_be",    32'(mem_be[k]), 32'(m_be[k]));
        end
    endtask

    initial begin : model_proc
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) mm[k][i] = init_word(k, i);
            m_pend[k]   = 0;
            m_streak[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // One complete request: hold until accepted, then wait for the response.
    task automatic xact(input int k, input bit isd, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output bit err, output int lat);
        int acc;
        bit got;
        @(posedge clk); #1;
        if (isd) begin
            d_req[k] = 1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd; d_be[k] = be;
        end else begin
            if_req[k] = 1; if_addr[k] = addr;
        end
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = isd ? d_ready[k] : if_ready[k];
        end
        acc = cyc;
        chk(k, "ready_wait", 32'(got), 32'd1);
        @(posedge clk); #1;
        if_req[k] = 0;
        d_req[k]  = 0;
        got = 0; rd = 0; err = 0; lat = -1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (isd ? d_rvalid[k] : if_rvalid[k]) begin
                got = 1;
                rd  = isd ? d_rdata[k] : if_rdata[k];
                err = d_err[k];
                lat = cyc - acc;
            end
        end
        chk(k, "rvalid_wait", 32'(got), 32'd1);
    endtask

    initial begin : stim
        logic [31:0] rd;
        bit          err;
        int          lat, ng, nr, nv, cnt;
        logic [31:0] mask;
        int          rc [4];
        int          vc [4];

        reset = 0; ram_init = 0;
        if_req = '0; d_req = '0; d_we = '0; if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;

        // Reset with both ports requesting: no ready may escape.
        if_req[0] = 1; d_req[0] = 1;
        repeat (2) @(posedge clk);
        #1 ram_init = 1;
        @(negedge clk);
        chk(0, "rst_if_ready", if_ready[0], 1'b0);
        chk(0, "rst_d_ready",  d_ready[0],  1'b0);
        chk(0, "rst_mem_en",   mem_en[0],   1'b0);
        @(posedge clk); #1;
        if_req[0] = 0; d_req[0] = 0; reset = 1;

        // Reset asserted while the MEM_LAT=2 instance is in WAIT.
        @(posedge clk); #1;
        if_req[1] = 1; if_addr[1] = 32'h8;
        ng = 0;
        for (int n = 0; n < 10 && ng == 0; n++) begin
            @(negedge clk);
            if (if_ready[1]) ng = 1;
        end
        chk(1, "pre_rst_accept", 32'(ng), 32'd1);
        @(posedge clk); #1 if_req[1] = 0;
        @(posedge clk); #1;
        reset = 0; if_req[1] = 1; d_req[1] = 1;
        @(negedge clk);
        chk(1, "rst_if_ready", if_ready[1], 1'b0);
        chk(1, "rst_d_ready",  d_ready[1],  1'b0);
        @(negedge clk);
        chk(1, "rst_if_rvalid", if_rvalid[1], 1'b0);
        @(posedge clk); #1;
        if_req[1] = 0; d_req[1] = 0; reset = 1;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (if_rvalid[1] || d_rvalid[1]) cnt++;
        end
        chk(1, "rvalid_after_reset", 32'(cnt), 32'd0);
        xact(1, 0, 0, 32'h8, 32'h0, 4'h0, rd, err, lat);
        chk(1, "post_rst_fetch", rd, 32'h0020_0113);
        chk(1, "post_rst_lat", 32'(lat), 32'd3);

        // Single fetch, MEM_LAT=1.
        xact(0, 0, 0, 32'h8, 32'h0, 4'h0, rd, err, lat);
        chk(0, "fetch_rdata", rd, 32'h0020_0113);
        chk(0, "fetch_lat", 32'(lat), 32'd2);
        chk(0, "fetch_err", 32'(err), 32'd0);

        // Store then load, then a single-byte store into lane 1.
        xact(0, 1, 1, 32'h4, 32'h3, 4'hF, rd, err, lat);
        chk(0, "sw_rdata", rd, 32'h0);
        chk(0, "sw_err", 32'(err), 32'd0);
        xact(0, 1, 0, 32'h4, 32'hFFFF_FFFF, 4'h0, rd, err, lat);
        chk(0, "lw_rdata", rd, 32'h3);
        chk(0, "lw_err", 32'(err), 32'd0);
        chk(0, "ram_word1", ram[0][1], 32'h3);
        xact(0, 1, 1, 32'h5, 32'h0000_AB00, 4'b0010, rd, err, lat);
        xact(0, 1, 0, 32'h4, 32'h0, 4'hF, rd, err, lat);
        chk(0, "sb_lw_rdata", rd, 32'h0000_AB03);

        // Both ports held: anti-starvation grant order.
        repeat (2) @(posedge clk);
        #1;
        d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h10; if_req[0] = 1; if_addr[0] = 32'h8;
        ng = 0; mask = 0;
        for (int n = 0; n < 60 && ng < 10; n++) begin
            @(negedge clk);
            if (d_ready[0]) begin mask = (mask << 1) | 32'd1; ng++; end
            else if (if_ready[0]) begin mask = mask << 1; ng++; end
        end
        @(posedge clk); #1;
        d_req[0] = 0; if_req[0] = 0;
        chk(0, "grant_count", 32'(ng), 32'd10);
        chk(0, "grant_order", mask, 32'b11_1101_1110);
        repeat (4) @(posedge clk);

        // Out-of-range word 64: no access, error response, memory untouched.
        xact(0, 1, 1, 32'h100, 32'hDEAD_BEEF, 4'hF, rd, err, lat);
        chk(0, "oor_sw_err", 32'(err), 32'd1);
        chk(0, "oor_sw_rdata", rd, 32'h0);
        xact(0, 1, 0, 32'h100, 32'h0, 4'h0, rd, err, lat);
        chk(0, "oor_lw_err", 32'(err), 32'd1);
        chk(0, "oor_lw_rdata", rd, 32'h0);
        chk(0, "oor_ram_word0", ram[0][0], init_word(0, 0));

        // Back-to-back fetches, MEM_LAT=2: one accept and one response every 3 cycles.
        @(posedge clk); #1;
        if_req[1] = 1; if_addr[1] = 32'hC;
        nr = 0; nv = 0;
        for (int n = 0; n < 40 && (nr < 4 || nv < 4); n++) begin
            @(negedge clk);
            if (if_ready[1] && nr < 4) begin rc[nr] = cyc; nr++; end
            if (if_rvalid[1] && nv < 4) begin vc[nv] = cyc; nv++; end
            if (nr == 4) begin
                @(posedge clk); #1 if_req[1] = 0;
            end
        end
        chk(1, "b2b_accepts", 32'(nr), 32'd4);
        chk(1, "b2b_responses", 32'(nv), 32'd4);
        for (int i = 0; i < 3; i++) chk(1, "b2b_accept_period", 32'(rc[i+1] - rc[i]), 32'd3);
        for (int i = 0; i < 4; i++) chk(1, "b2b_resp_latency", 32'(vc[i] - rc[i]), 32'd3);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
